ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xF4 (enable scanning), over the same ps2_clk/ps2_data lines the keyboard receiver listens on. It drives the lines open-drain through enable outputs; the top level builds the tri-state buffers, pulling each inout low while its enable is 1 and leaving it high-Z otherwise. It performs the full handshake: clock inhibit, start-bit request, device-clocked data, odd parity, stop bit, and a check for the device's ACK.

---
 rtl/ps2_host_tx.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device-generated clock edges and checks the device's ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYC  = 12000,
  parameter int START_TO_CYC = 1500000,
  parameter int XFER_TO_CYC  = 200000,
  parameter int FILTER_CYC   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] dbg_state
);

  // Handshake: tx_start is a one-cycle request taken only while tx_busy=0 (no
  // queueing); each accepted request ends with exactly one tx_done pulse, with
  // tx_err valid alongside it, unless reset aborts the transfer first.

  localparam int TMAX_IS = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
  localparam int TMAX    = (TMAX_IS > XFER_TO_CYC) ? TMAX_IS : XFER_TO_CYC;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int FW      = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO_CYC - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TO_CYC - 1);
  localparam logic [FW-1:0] FLT_LAST   = FW'(FILTER_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT_CLK,
    S_XFER,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d, fe_q, fe_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  state_t        state_q;
  logic [TW-1:0] tmr_q, tmr_inc;
  logic [3:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          busy_q, done_q, err_q, clk_oe_q, data_oe_q;

  // The filtered level only moves after FILTER_CYC consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FLT_LAST) filt_d = clk_s2_q;
      else                    fcnt_d = fcnt_q + 1'b1;
    end
    fe_d = filt_q & ~filt_d;
  end

  // Idle bus level is high, so the conditioning flops reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      fe_q     <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      fe_q     <= fe_d;
    end
  end

  assign tmr_inc = (&tmr_q) ? tmr_q : tmr_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (tx_start) begin
            shift_q  <= tx_data;
            par_q    <= ~^tx_data;
            busy_q   <= 1'b1;
            clk_oe_q <= 1'b1;
            tmr_q    <= '0;
            state_q  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (tmr_q == INH_LAST) begin
            data_oe_q <= 1'b1;
            state_q   <= S_REQ;
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        S_REQ: begin
          clk_oe_q <= 1'b0;
          tmr_q    <= '0;
          state_q  <= S_WAIT_CLK;
        end
        S_WAIT_CLK: begin
          if (fe_q) begin
            data_oe_q <= ~shift_q[0];
            bitcnt_q  <= 4'd1;
            tmr_q     <= '0;
            state_q   <= S_XFER;
          end else if (tmr_q == START_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        S_XFER: begin
          if (tmr_q == XFER_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            tmr_q <= tmr_inc;
            if (fe_q) begin
              bitcnt_q <= bitcnt_q + 4'd1;
              // Line changes the cycle after fe, well before the device's rising-edge sample.
              if (bitcnt_q <= 4'd7) begin
                data_oe_q <= ~shift_q[bitcnt_q[2:0]];
              end else if (bitcnt_q == 4'd8) begin
                data_oe_q <= ~par_q;
              end else if (bitcnt_q == 4'd9) begin
                data_oe_q <= 1'b0;
              end else if (dat_s2_q) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                done_q    <= 1'b1;
                err_q     <= 1'b1;
                state_q   <= S_ERR;
              end else begin
                state_q <= S_WAIT_IDLE;
              end
            end
          end
        end
        S_WAIT_IDLE: begin
          if (tmr_q == XFER_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= S_ERR;
          end else if (filt_q && dat_s2_q) begin
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            tmr_q <= tmr_inc;
          end
        end
        S_DONE, S_ERR: begin
          busy_q   <= 1'b0;
          tmr_q    <= '0;
          bitcnt_q <= '0;
          state_q  <= S_IDLE;
        end
        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on wired-AND lines, a per-cycle
// protocol model of busy/oe/done/err, and directed frames with literal expectations.
module tb_ps2_host_tx;

  localparam int INH  = 1200;
  localparam int STO  = 500;
  localparam int XTO  = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 40;

  logic       clk, rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [2:0] dbg_state;
  logic       dev_clk, dev_data;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .START_TO_CYC(STO),
    .XFER_TO_CYC (XTO),
    .FILTER_CYC  (FLT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame as the device must see it: 8 data bits LSB-first, odd parity, stop=1.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  // ---------------- per-cycle protocol model ----------------
  bit mdl_busy  = 0;
  bit prev_done = 0;
  bit err_hold  = 0;
  bit exp_err   = 0;
  bit exp_clk_oe;
  int acc_cyc   = 0;
  int off;
  int n_done    = 0;
  int done_cyc  = 0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      mdl_busy  = 0;
      prev_done = 0;
      err_hold  = 0;
      chk("rst_busy", 32'(tx_busy), 0);
      chk("rst_done", 32'(tx_done), 0);
      chk("rst_err", 32'(tx_err), 0);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
      chk("rst_data_oe", 32'(ps2_data_oe), 0);
      chk("rst_state_idle", 32'(dbg_state), 0);
    end else begin
      if (tx_start && !mdl_busy) begin
        mdl_busy = 1;
        acc_cyc  = cyc;
      end else if (prev_done) begin
        mdl_busy = 0;
      end
      off = cyc - acc_cyc;
      // Bus is held low for the inhibit time plus the one request cycle.
      exp_clk_oe = mdl_busy && (off <= INH);
      chk("busy", 32'(tx_busy), 32'(mdl_busy));
      chk("clk_oe", 32'(ps2_clk_oe), 32'(exp_clk_oe));
      if (!mdl_busy)
        chk("data_oe_idle", 32'(ps2_data_oe), 0);
      else if (off < INH)
        chk("data_oe_inhibit", 32'(ps2_data_oe), 0);
      else if (off == INH)
        chk("data_oe_request", 32'(ps2_data_oe), 1);
      if (tx_done) begin
        chk("done_while_busy", 32'(mdl_busy), 1);
        chk("done_err", 32'(tx_err), 32'(exp_err));
        chk("done_data_oe", 32'(ps2_data_oe), 0);
        err_hold = exp_err;
        n_done++;
        done_cyc = cyc;
      end else begin
        chk("err_hold", 32'(tx_err), 32'(err_hold));
      end
      prev_done = tx_done;
    end
  end

  // ---------------- driver / device tasks ----------------
  int t_first = 0;
  logic [9:0] got;

  task automatic send(input logic [7:0] d, input bit e);
    @(negedge clk);
    exp_err  = e;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic dev_run(input int n_fe, input bit ack, input bit glitch, output logic [9:0] bits);
    int w;
    w    = 0;
    bits = '0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && w < INH + 200) begin
      @(negedge clk);
      w++;
    end
    chk("dev_sees_request", 32'(w < INH + 200), 1);
    if (w >= INH + 200) return;
    repeat (60) @(negedge clk);
    t_first = cyc;
    for (int i = 0; i < n_fe; i++) begin
      if (i == 10) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2_data_in;
      if (glitch && i == 3) begin
        repeat (20) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 23) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i == 10) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int prev, input string nm);
    int k;
    k = 0;
    while (n_done == prev && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(n_done - prev), 1);
  endtask

  task automatic frame_chk(input string nm, input logic [9:0] bits, input logic [9:0] lit);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      chk({nm, "_queue_empty"}, 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_model"}, 32'(bits), 32'(e));
    end
    chk({nm, "_literal"}, 32'(bits), 32'(lit));
  endtask

  // ---------------- directed sequence ----------------
  int n0, k, t_rel, d;

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    chk("model_frame_ED", 32'(frame_of(8'hED)), 32'h3ED);
    chk("model_frame_F4", 32'(frame_of(8'hF4)), 32'h2F4);

    // 0xED with ACK
    n0 = n_done;
    exp_q.push_back(frame_of(8'hED));
    send(8'hED, 1'b0);
    dev_run(11, 1'b1, 1'b0, got);
    wait_done(n0, "ed_done");
    frame_chk("ed_frame", got, 10'h3ED);

    // 0xF4 with ACK; a second request with 0x00 while busy must be ignored
    n0 = n_done;
    exp_q.push_back(frame_of(8'hF4));
    send(8'hF4, 1'b0);
    repeat (100) @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    dev_run(11, 1'b1, 1'b0, got);
    wait_done(n0, "f4_done");
    frame_chk("f4_frame", got, 10'h2F4);
    repeat (200) @(negedge clk);
    chk("no_queued_request", 32'(n_done - n0), 1);

    // 0xF4 with the device leaving data high at the ACK edge
    n0 = n_done;
    exp_q.push_back(frame_of(8'hF4));
    send(8'hF4, 1'b1);
    dev_run(11, 1'b0, 1'b0, got);
    wait_done(n0, "nack_done");
    frame_chk("nack_frame", got, 10'h2F4);

    // device never clocks: error exactly STO cycles after the clock release
    n0 = n_done;
    send(8'h55, 1'b1);
    k = 0;
    while (ps2_clk_oe !== 1'b0 && k < INH + 100) begin
      @(negedge clk);
      k++;
    end
    t_rel = cyc;
    chk("release_seen", 32'(k < INH + 100), 1);
    wait_done(n0, "start_to_done");
    chk("start_timeout_cycles", 32'(done_cyc - t_rel), 32'(STO));

    // device stops after 4 edges: error XTO cycles after its first edge (+input latency)
    n0 = n_done;
    send(8'hA5, 1'b1);
    dev_run(4, 1'b1, 1'b0, got);
    wait_done(n0, "xfer_to_done");
    d = done_cyc - t_first;
    chk("xfer_timeout_window", 32'(d >= XTO && d <= XTO + FLT + 4), 1);
    chk("xfer_partial_bits", 32'(got[3:0]), 32'h5);

    // 3-cycle glitch on the clock line mid-frame
    n0 = n_done;
    exp_q.push_back(frame_of(8'hED));
    send(8'hED, 1'b0);
    dev_run(11, 1'b1, 1'b1, got);
    wait_done(n0, "glitch_done");
    frame_chk("glitch_frame", got, 10'h3ED);

    // reset after 5 edges of 0xE5 (bit4=0, so data is being pulled low)
    send(8'hE5, 1'b0);
    dev_run(5, 1'b1, 1'b0, got);
    chk("pre_reset_data_oe", 32'(ps2_data_oe), 1);
    chk("pre_reset_busy", 32'(tx_busy), 1);
    chk("pre_reset_bits", 32'(got[4:0]), 32'h05);
    n0 = n_done;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_data_oe", 32'(ps2_data_oe), 0);
    chk("async_rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("async_rst_busy", 32'(tx_busy), 0);
    chk("async_rst_done", 32'(tx_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("no_done_after_reset", 32'(n_done - n0), 0);

    // fresh 0xF4 after reset
    n0 = n_done;
    exp_q.push_back(frame_of(8'hF4));
    send(8'hF4, 1'b0);
    dev_run(11, 1'b1, 1'b0, got);
    wait_done(n0, "post_reset_done");
    frame_chk("post_reset_frame", got, 10'h2F4);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
